seg_scan_mux: RTL

Time-multiplexed seven-segment scan driver downstream of the traffic-light top. It takes the eight per-digit segment patterns produced by the two display stages (direction 1 and direction 2, red and green, two digits each) and drives one shared segment bus plus eight one-hot digit enables. Consecutive digits are separated by a blanking dead time to prevent ghosting, and a PWM brightness control and a lamp test are provided. Scan rate comes from the existing 1 kHz divider output, used as a one-clock strobe.

---
 rtl/disp_pkg.sv | 35 +++
 rtl/seg_scan_mux.sv | 97 +++++++++
 2 files changed

// File: rtl/disp_pkg.sv
// Shared display definitions: digit geometry, segment constants, scan
// states and the seg_in packing order used by the traffic-light display.
package disp_pkg;

    localparam int unsigned NUM_DIGITS = 8;
    localparam int unsigned SEG_W      = 7;

    // Segments are active-low: all ones blanks a digit, all zeros lights it.
    localparam logic [SEG_W-1:0] SEG_OFF    = 7'h7F;
    localparam logic [SEG_W-1:0] SEG_ALL_ON = 7'h00;

    typedef enum logic {
        BLANK,
        ON
    } scan_state_t;

    // Digit k occupies seg_in[7k+6:7k].
    localparam int unsigned DIG_D1_RED0   = 0;
    localparam int unsigned DIG_D1_RED1   = 1;
    localparam int unsigned DIG_D1_GREEN0 = 2;
    localparam int unsigned DIG_D1_GREEN1 = 3;
    localparam int unsigned DIG_D2_RED0   = 4;
    localparam int unsigned DIG_D2_RED1   = 5;
    localparam int unsigned DIG_D2_GREEN0 = 6;
    localparam int unsigned DIG_D2_GREEN1 = 7;

    // Digit-enable decode for a scan index.
    function automatic logic [NUM_DIGITS-1:0] onehot(input logic [2:0] idx);
        logic [NUM_DIGITS-1:0] r;
        r      = '0;
        r[idx] = 1'b1;
        return r;
    endfunction

endpackage

// File: rtl/seg_scan_mux.sv
// Seven-segment scan driver: walks eight digits on a shared segment bus
// with blanking dead time between digits, PWM brightness and lamp test.
module seg_scan_mux
    import disp_pkg::*;
#(
    parameter int unsigned BLANK_CYCLES = 2
) (
    input  logic                        clock,
    input  logic                        rst,
    input  logic                        tick,
    input  logic [NUM_DIGITS*SEG_W-1:0] seg_in,
    input  logic                        lamp_test,
    input  logic [2:0]                  brightness,
    output logic [SEG_W-1:0]            seg_out,
    output logic [NUM_DIGITS-1:0]       dig_en,
    output logic                        frame_start
);

    localparam int unsigned BCW = (BLANK_CYCLES > 0) ? $clog2(BLANK_CYCLES + 1) : 1;
    localparam logic [BCW-1:0] BLANK_LOAD = BCW'(BLANK_CYCLES);
    localparam logic [BCW-1:0] BCNT_ONE   = BCW'(1);

    scan_state_t            state, state_nx;
    logic [BCW-1:0]         bcnt, bcnt_nx;
    logic [2:0]             idx, idx_nx;
    logic [2:0]             pwm, pwm_nx;
    logic [SEG_W-1:0]       seg_nx;
    logic [NUM_DIGITS-1:0]  dig_nx;
    logic                   fs_nx;
    logic [SEG_W-1:0]       digit_pat;

    // Pattern of the currently selected digit.
    always_comb digit_pat = seg_in[int'(idx)*SEG_W +: SEG_W];

    // Next-state and next-output decode; outputs are registered below so
    // seg_out doubles as the per-slot capture of the digit pattern.
    always_comb begin
        state_nx = state;
        bcnt_nx  = bcnt;
        idx_nx   = idx;
        pwm_nx   = pwm;
        seg_nx   = seg_out;
        dig_nx   = dig_en;
        fs_nx    = 1'b0;
        if (tick) begin
            state_nx = BLANK;
            bcnt_nx  = BLANK_LOAD;
            idx_nx   = idx + 3'd1;
            pwm_nx   = '0;
            seg_nx   = SEG_OFF;
            dig_nx   = '0;
            fs_nx    = (idx == 3'd7);
        end else begin
            case (state)
                BLANK: begin
                    seg_nx = SEG_OFF;
                    dig_nx = '0;
                    if (bcnt == '0) begin
                        state_nx = ON;
                        pwm_nx   = '0;
                        seg_nx   = lamp_test ? SEG_ALL_ON : digit_pat;
                        dig_nx   = onehot(idx);
                    end else begin
                        bcnt_nx = bcnt - BCNT_ONE;
                    end
                end
                ON: begin
                    pwm_nx = pwm + 3'd1;
                    dig_nx = (pwm_nx <= brightness) ? onehot(idx) : '0;
                end
                default: state_nx = BLANK;
            endcase
        end
    end

    // State, counters and registered outputs.
    always_ff @(posedge clock) begin
        if (!rst) begin
            state       <= BLANK;
            bcnt        <= '0;
            idx         <= 3'd7;
            pwm         <= '0;
            seg_out     <= SEG_OFF;
            dig_en      <= '0;
            frame_start <= 1'b0;
        end else begin
            state       <= state_nx;
            bcnt        <= bcnt_nx;
            idx         <= idx_nx;
            pwm         <= pwm_nx;
            seg_out     <= seg_nx;
            dig_en      <= dig_nx;
            frame_start <= fs_nx;
        end
    end

endmodule
